// File: rtl/seq_pkg.sv
// Shared types and constants for the instruction sequencer.
// Pure declarations; no logic or latency of its own.
// No flow control here; consumers own the handshakes.
package seq_pkg;

   localparam int INSTR_W    = 8;
   localparam int RAM_AW     = 2;
   localparam int GPR_AW     = 3;
   localparam int ALU_CODE_W = 3;
   localparam int OP_W       = 3;

   // Instruction field positions: opcode [7:5], gpr [4:2], ram [1:0]
   localparam int OP_LSB  = 5;
   localparam int GPR_LSB = 2;
   localparam int RAM_LSB = 0;

   localparam logic [OP_W-1:0] OP_STORE  = 3'b000;
   localparam logic [OP_W-1:0] OP_LOOKUP = 3'b001;
   localparam logic [OP_W-1:0] OP_RMOV   = 3'b010;
   localparam logic [OP_W-1:0] OP_ALU    = 3'b011;

   localparam logic [1:0] SEL_RAM = 2'b00;
   localparam logic [1:0] SEL_ROM = 2'b01;
   localparam logic [1:0] SEL_ALU = 2'b10;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_RAMWR = 3'd1,
      S_RAMRD = 3'd2,
      S_ROMRD = 3'd3,
      S_GPRWR = 3'd4,
      S_ALU   = 3'd5,
      S_NOP   = 3'd6,
      S_ILL   = 3'd7
   } seq_state_t;

   // Last step of a sequence: the next instruction may be taken in this cycle.
   function automatic logic is_final(input seq_state_t s);
      return (s == S_RAMWR) || (s == S_GPRWR) || (s == S_ALU) ||
             (s == S_NOP)   || (s == S_ILL);
   endfunction

endpackage

// File: rtl/seq_step_decode.sv
// Next-step function of the sequencer FSM (state, opcode, ram field).
// Purely combinational, zero latency.
// No handshake; the caller qualifies i_accept with its own ready.
module seq_step_decode
   import seq_pkg::*;
(
   input  seq_state_t      i_state,
   input  logic            i_accept,
   input  logic [OP_W-1:0] i_opcode,
   input  logic [1:0]      i_ram_field,
   output seq_state_t      o_state_nxt
);

   // On accept, jump to the first step of the new opcode; otherwise walk the current sequence.
   always_comb begin
      o_state_nxt = S_IDLE;
      if (i_accept) begin
         case (i_opcode)
            OP_STORE:  o_state_nxt = S_RAMWR;
            OP_LOOKUP: o_state_nxt = S_RAMRD;
            // A register move from RAM slot 0 is reserved and rejected.
            OP_RMOV:   o_state_nxt = (i_ram_field == 2'b00) ? S_ILL : S_RAMRD;
            OP_ALU:    o_state_nxt = S_ALU;
            default:   o_state_nxt = S_NOP;
         endcase
      end else begin
         case (i_state)
            S_RAMRD: o_state_nxt = (i_opcode == OP_LOOKUP) ? S_ROMRD : S_GPRWR;
            S_ROMRD: o_state_nxt = S_GPRWR;
            default: o_state_nxt = S_IDLE;
         endcase
      end
   end

endmodule

// File: rtl/instr_sequencer.sv
// Expands one 8-bit instruction into a timed sequence of datapath enable strobes.
// Step 1 appears the cycle after the handshake; all outputs are Moore (registered state + latch).
// instr_ready is high in IDLE and in the last step, so back-to-back instructions run bubble-free.
module instr_sequencer
   import seq_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  instr_valid,
   input  logic [INSTR_W-1:0]    instr_data,
   output logic                  instr_ready,
   output logic                  ram_rd_en,
   output logic                  ram_wr_en,
   output logic [RAM_AW-1:0]     ram_address,
   output logic                  rom_rd_en,
   output logic                  rom_kernal_en,
   output logic                  rom_rst_n,
   output logic                  gpr_wr_en,
   output logic [GPR_AW-1:0]     gpr_address,
   output logic [1:0]            sel_decR2R,
   output logic                  alu_en,
   output logic [ALU_CODE_W-1:0] alu_code,
   output logic                  done,
   output logic                  illegal_op
);

   seq_state_t         r_state;
   seq_state_t         w_state_nxt;
   logic [INSTR_W-1:0] r_instr;
   logic               r_live;      // low in reset and the cycle it is released
   logic               w_accept;
   logic [OP_W-1:0]    w_dec_op;
   logic [1:0]         w_dec_ram;
   logic [OP_W-1:0]    w_lat_op;

   assign w_lat_op    = r_instr[OP_LSB +: OP_W];
   assign instr_ready = r_live && ((r_state == S_IDLE) || is_final(r_state));
   assign w_accept    = instr_valid && instr_ready;

   // The first step must be chosen from the incoming word; later steps use the latch.
   assign w_dec_op  = w_accept ? instr_data[OP_LSB +: OP_W]  : w_lat_op;
   assign w_dec_ram = w_accept ? instr_data[RAM_LSB +: 2]    : r_instr[RAM_LSB +: 2];

   seq_step_decode u_step_decode (
      .i_state     (r_state),
      .i_accept    (w_accept),
      .i_opcode    (w_dec_op),
      .i_ram_field (w_dec_ram),
      .o_state_nxt (w_state_nxt)
   );

   // State register, instruction latch and post-reset live flag.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_instr <= '0;
         r_live  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_live  <= 1'b1;
         if (w_accept) begin
            r_instr <= instr_data;
         end
      end
   end

   // Addresses and ALU code follow the latch, so they hold between instructions.
   assign ram_address   = r_instr[RAM_LSB +: RAM_AW];
   assign gpr_address   = r_instr[GPR_LSB +: GPR_AW];
   assign alu_code      = w_lat_op;
   assign rom_rst_n     = r_live;
   assign rom_kernal_en = 1'b0;

   // Moore strobe decode: exactly one strobe group per step.
   always_comb begin
      ram_rd_en  = 1'b0;
      ram_wr_en  = 1'b0;
      rom_rd_en  = 1'b0;
      gpr_wr_en  = 1'b0;
      alu_en     = 1'b0;
      sel_decR2R = SEL_RAM;
      done       = 1'b0;
      illegal_op = 1'b0;
      case (r_state)
         S_RAMWR: begin
            ram_wr_en = 1'b1;
            done      = 1'b1;
         end
         S_RAMRD: begin
            ram_rd_en  = 1'b1;
            sel_decR2R = SEL_RAM;
         end
         S_ROMRD: begin
            rom_rd_en = 1'b1;
         end
         S_GPRWR: begin
            gpr_wr_en  = 1'b1;
            sel_decR2R = (w_lat_op == OP_LOOKUP) ? SEL_ROM : SEL_RAM;
            done       = 1'b1;
         end
         S_ALU: begin
            alu_en     = 1'b1;
            sel_decR2R = SEL_ALU;
            done       = 1'b1;
         end
         S_NOP: begin
            done = 1'b1;
         end
         S_ILL: begin
            illegal_op = 1'b1;
         end
         default: begin
         end
      endcase
   end

endmodule
